alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised successor to the execute-stage ALU.
- Keeps all single-cycle ops; adds signed SLT and SRA.
- Adds an iterative multiply/divide unit with architectural HI/LO registers and MFHI/MFLO.
- Sits in EX; pipeline control stalls on ~ready and consumes results on result_valid.

Parameters:
- DATA_W, 32, operand/result width (even, >=4).
- SHAMT_W, $clog2(DATA_W), shift-amount width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; accepted on a rising edge where start && ready.
- ALUOp  input  4  operation code, sampled at accept.
- src1  input  DATA_W  operand A (rs), sampled at accept.
- src2  input  DATA_W  operand B (rt), sampled at accept.
- shamt  input  SHAMT_W  shift amount, sampled at accept.
- ready  output  1  high when idle and able to accept.
- result_valid  output  1  one-cycle pulse; ALU_result/Zero valid this cycle.
- ALU_result  output  DATA_W  registered result.
- Zero  output  1  registered, equals (ALU_result == 0).
- hi  output  DATA_W  HI register.
- lo  output  DATA_W  LO register.

Behaviour:
- Clock is clk. Reset rst is asynchronous, active-high.
- Reset values: ready=1, result_valid=0, ALU_result=0, Zero=1, hi=0, lo=0, state=IDLE, iteration counter=0.
- Op codes:
  - 0010 add, 0110 sub, 0000 and, 0001 or, 1101 xor, 1100 nor.
  - 0111 slt (signed compare, result 1/0).
  - 1001 sll src2<<shamt; 1110 srl src2>>shamt; 1010 sra (arithmetic shift of src2).
  - 0011 mult, 0100 multu, 0101 div, 1000 divu.
  - 1111 mfhi (result=hi), 1011 mflo (result=lo).
  - Any other code gives result 0.
- Arithmetic: add/sub wrap modulo 2^DATA_W, no overflow flag. Zero is always computed from the registered ALU_result.
- States:
  - IDLE: ready=1.
  - MUL: DATA_W shift-add iterations on operand magnitudes.
  - DIV: DATA_W restoring shift-subtract iterations on magnitudes.
  - FIX: sign correction and writeback of hi/lo/ALU_result.
- Single-cycle ops (incl. mfhi/mflo):
  - Result registered at the accept edge; result_valid high the following cycle.
  - Latency is 1 edge and state stays IDLE.
- mult/multu:
  - Accept edge → MUL, counter=0.
  - After DATA_W iterations → FIX.
  - FIX writes {hi,lo} = full 2*DATA_W product, ALU_result=lo, result_valid=1, then → IDLE.
  - result_valid rises DATA_W+2 edges after accept, counting the accept edge as 1.
- div/divu: same timing, with lo=quotient, hi=remainder, ALU_result=lo.
- Signed rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Product sign = sign(src1) XOR sign(src2).
  - div of most-negative by −1 gives lo=most-negative, hi=0.
- Divide by zero (src2==0, div or divu):
  - No iteration. Accept → FIX directly; result_valid 2 edges after accept.
  - Writes lo=all-ones, hi=src1, ALU_result=all-ones.
- hi/lo change only in FIX. Single-cycle ops never modify hi/lo.
- start while ready=0 is ignored; no queuing. Operands are held internally, so input changes during MUL/DIV have no effect.
- A new start may be accepted in the same cycle result_valid is high (back-to-back).
- Reset mid-operation aborts immediately: outputs return to reset values and hi/lo are cleared.

Decomposition:
- Shared package alu_pkg holds ALUOp localparams (ALU_ADD … ALU_MFLO) and the state enum (IDLE, MUL, DIV, FIX).
- One sub-module: alu_muldiv_iter, the iterative multiply/divide datapath. It takes magnitudes, a mode and a go signal, and returns the raw product or quotient/remainder plus done.
- The top level does decode, sign handling, single-cycle ops and hi/lo.

Test Plan:
- Single-cycle ops, DATA_W=32:
  - add 0x7FFFFFFF+1 → 0x80000000, result_valid 1 cycle after accept.
  - sub 5−5 → 0 with Zero=1.
  - slt −1<1 → 1.
  - sra 0x80000000 by 4 → 0xF8000000.
- mult, DATA_W=32: −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB, result_valid exactly 34 edges after accept, ready=0 for edges 1..33.
- div, DATA_W=8: −7 / 2 → lo=0xFD (−3), hi=0xFF (−1). divu 200/7 → lo=28, hi=4. Latency 10 edges.
- divu by zero, DATA_W=32: src1=0x1234 → lo=0xFFFFFFFF, hi=0x1234, result_valid 2 edges after accept.
- start pulsed during MUL is ignored. Back-to-back mfhi accepted on the result_valid cycle returns the new hi.
- rst asserted mid-DIV → ready=1, hi=lo=0, result_valid=0 immediately. Following add 2+3 → 5 with normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_muldiv execute-stage unit.
// Holds the 4-bit ALUOp encodings, the control state enum and a small
// decode helper used by the top level.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_MULT  = 4'b0011;
  localparam logic [3:0] ALU_MULTU = 4'b0100;
  localparam logic [3:0] ALU_DIV   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_DIVU  = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_MFLO  = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_XOR   = 4'b1101;
  localparam logic [3:0] ALU_SRL   = 4'b1110;
  localparam logic [3:0] ALU_MFHI  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  // True for the multiply/divide codes that treat operands as two's complement.
  function automatic logic is_signed_md(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/result bundle between pipeline control and the ALU.
//   master: drives start, ALUOp, src1, src2, shamt; observes the results.
//   slave : the ALU; drives ready, result_valid, ALU_result, Zero, hi, lo.
interface alu_muldiv_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
);
  logic               start;
  logic [3:0]         ALUOp;
  logic [DATA_W-1:0]  src1;
  logic [DATA_W-1:0]  src2;
  logic [SHAMT_W-1:0] shamt;
  logic               ready;
  logic               result_valid;
  logic [DATA_W-1:0]  ALU_result;
  logic               Zero;
  logic [DATA_W-1:0]  hi;
  logic [DATA_W-1:0]  lo;

  modport master (
    output start, ALUOp, src1, src2, shamt,
    input  ready, result_valid, ALU_result, Zero, hi, lo
  );

  modport slave (
    input  start, ALUOp, src1, src2, shamt,
    output ready, result_valid, ALU_result, Zero, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned multiply / restoring divide datapath.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   go_i          load operands and start DATA_W iterations
//   div_i         mode captured at go_i: 0 = multiply, 1 = divide
//   a_i, b_i      unsigned magnitudes (multiplier/dividend, multiplicand/divisor)
//   done_o        high during the cycle whose edge performs the last iteration
//   hi_o, lo_o    raw product {hi,lo}, or remainder (hi) / quotient (lo)
module alu_muldiv_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go_i,
  input  logic              div_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic              busy_q;
  logic              div_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q;  // partial product high half / partial remainder
  logic [DATA_W-1:0] mq_q;   // multiplier shifting out / quotient shifting in
  logic [DATA_W-1:0] b_q;

  logic [DATA_W:0]   sum_s;
  logic [DATA_W:0]   addend_s;
  logic [DATA_W:0]   shifted_s;
  logic [DATA_W:0]   diff_s;
  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] mq_d;

  assign done_o = busy_q && (cnt_q == LAST);
  assign hi_o   = acc_q;
  assign lo_o   = mq_q;

  // One iteration step: shift-add for multiply, shift-subtract-restore for divide.
  always_comb begin
    sum_s     = {1'b0, acc_q} + {1'b0, b_q};
    addend_s  = mq_q[0] ? sum_s : {1'b0, acc_q};
    shifted_s = {acc_q, mq_q[DATA_W-1]};
    diff_s    = shifted_s - {1'b0, b_q};
    acc_d     = acc_q;
    mq_d      = mq_q;
    if (div_q) begin
      // Remainder stays below the divisor, so bit DATA_W of diff is a clean borrow.
      if (!diff_s[DATA_W]) begin
        acc_d = diff_s[DATA_W-1:0];
        mq_d  = {mq_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_d = shifted_s[DATA_W-1:0];
        mq_d  = {mq_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_d = addend_s[DATA_W:1];
      mq_d  = {addend_s[0], mq_q[DATA_W-1:1]};
    end
  end

  // Operand load and iteration sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      mq_q   <= '0;
      b_q    <= '0;
    end else if (go_i) begin
      busy_q <= 1'b1;
      div_q  <= div_i;
      cnt_q  <= '0;
      acc_q  <= '0;
      mq_q   <= a_i;
      b_q    <= b_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with iterative multiply/divide and HI/LO.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (aborts any operation, clears HI/LO)
//   bus  alu_muldiv_if.slave: start/ALUOp/src1/src2/shamt in,
//        ready/result_valid/ALU_result/Zero/hi/lo out (all registered)
// Single-cycle ops register their result at the accept edge. Multiply and
// divide run DATA_W iterations in alu_muldiv_iter on operand magnitudes, then
// a FIX cycle applies signs and writes HI/LO/ALU_result.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input logic        clk,
  input logic        rst,
  alu_muldiv_if.slave bus
);

  logic [DATA_W-1:0]  src1;
  logic [DATA_W-1:0]  src2;
  logic [SHAMT_W-1:0] shamt;
  logic [3:0]         op;

  assign src1  = bus.src1;
  assign src2  = bus.src2;
  assign shamt = bus.shamt;
  assign op    = bus.ALUOp;

  state_e            state_q;
  logic              ready_q;
  logic              valid_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              md_div_q;
  logic              neg_res_q;   // product or quotient must be negated
  logic              neg_rem_q;   // remainder must be negated
  logic              div_zero_q;
  logic [DATA_W-1:0] opa_q;       // raw src1, becomes HI on divide by zero

  logic              accept;
  logic              is_mul;
  logic              is_div;
  logic              sgn;
  logic              neg_a;
  logic              neg_b;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic              div_zero;
  logic              go;
  logic              iter_done;
  logic [DATA_W-1:0] raw_hi;
  logic [DATA_W-1:0] raw_lo;
  logic [DATA_W-1:0] single_d;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_signed;
  logic [DATA_W-1:0] fix_hi_d;
  logic [DATA_W-1:0] fix_lo_d;

  assign accept   = bus.start && ready_q;
  assign is_mul   = (op == ALU_MULT) || (op == ALU_MULTU);
  assign is_div   = (op == ALU_DIV) || (op == ALU_DIVU);
  assign sgn      = is_signed_md(op);
  assign neg_a    = sgn && src1[DATA_W-1];
  assign neg_b    = sgn && src2[DATA_W-1];
  assign mag_a    = neg_a ? -src1 : src1;
  assign mag_b    = neg_b ? -src2 : src2;
  assign div_zero = is_div && (src2 == '0);
  assign go       = accept && (is_mul || (is_div && !div_zero));

  assign bus.ready        = ready_q;
  assign bus.result_valid = valid_q;
  assign bus.ALU_result   = result_q;
  assign bus.Zero         = zero_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;

  alu_muldiv_iter #(
    .DATA_W (DATA_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .go_i   (go),
    .div_i  (is_div),
    .a_i    (mag_a),
    .b_i    (mag_b),
    .done_o (iter_done),
    .hi_o   (raw_hi),
    .lo_o   (raw_lo)
  );

  // Single-cycle result selection.
  always_comb begin
    single_d = '0;
    case (op)
      ALU_ADD:  single_d = src1 + src2;
      ALU_SUB:  single_d = src1 - src2;
      ALU_AND:  single_d = src1 & src2;
      ALU_OR:   single_d = src1 | src2;
      ALU_XOR:  single_d = src1 ^ src2;
      ALU_NOR:  single_d = ~(src1 | src2);
      ALU_SLT:  single_d = {{(DATA_W-1){1'b0}}, ($signed(src1) < $signed(src2))};
      ALU_SLL:  single_d = src2 << shamt;
      ALU_SRL:  single_d = src2 >> shamt;
      ALU_SRA:  single_d = $signed(src2) >>> shamt;
      ALU_MFHI: single_d = hi_q;
      ALU_MFLO: single_d = lo_q;
      default:  single_d = '0;
    endcase
  end

  // Sign correction of the raw iterator outputs for the FIX writeback.
  always_comb begin
    prod        = {raw_hi, raw_lo};
    prod_signed = neg_res_q ? -prod : prod;
    fix_hi_d    = '0;
    fix_lo_d    = '0;
    if (div_zero_q) begin
      fix_hi_d = opa_q;
      fix_lo_d = '1;
    end else if (md_div_q) begin
      // Remainder follows the dividend's sign; quotient truncates toward zero.
      fix_hi_d = neg_rem_q ? -raw_hi : raw_hi;
      fix_lo_d = neg_res_q ? -raw_lo : raw_lo;
    end else begin
      fix_hi_d = prod_signed[2*DATA_W-1:DATA_W];
      fix_lo_d = prod_signed[DATA_W-1:0];
    end
  end

  // Control FSM with registered outputs and HI/LO writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      hi_q       <= '0;
      lo_q       <= '0;
      md_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opa_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            md_div_q   <= is_div;
            neg_res_q  <= neg_a ^ neg_b;
            neg_rem_q  <= neg_a;
            div_zero_q <= div_zero;
            opa_q      <= src1;
            if (is_mul) begin
              state_q <= MUL;
              ready_q <= 1'b0;
            end else if (is_div) begin
              // Divide by zero skips iteration and goes straight to writeback.
              state_q <= div_zero ? FIX : DIV;
              ready_q <= 1'b0;
            end else begin
              result_q <= single_d;
              zero_q   <= (single_d == '0);
              valid_q  <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          if (iter_done) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q     <= fix_hi_d;
          lo_q     <= fix_lo_d;
          result_q <= fix_lo_d;
          zero_q   <= (fix_lo_d == '0);
          valid_q  <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed, table-driven bench for alu_muldiv at DATA_W=32
// and DATA_W=8, plus hand-written multi-cycle sequences (mult timing with an
// ignored start, back-to-back mfhi, reset during divide).
module tb_alu_muldiv;
  import alu_pkg::*;

  logic clk;
  logic rst;

  alu_muldiv_if #(.DATA_W(32)) b32 ();
  alu_muldiv_if #(.DATA_W(8))  b8 ();

  alu_muldiv #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  alu_muldiv #(.DATA_W(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

  always #5 clk = ~clk;

  int n_total;
  int n_pass;

  typedef struct {
    bit          w8;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    int          lat;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(bit w8, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [4:0] sh, int lat, logic [31:0] res,
                              logic [31:0] hi, logic [31:0] lo);
    vec_t v;
    v.w8 = w8; v.op = op; v.a = a; v.b = b; v.sh = sh; v.lat = lat;
    v.res = res; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Issue one op starting away from an edge; check timing and results at edge lat.
  task automatic run_op(input string nm, input bit w8, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input int lat, input logic [31:0] exp_res,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int bad;
    logic rv;
    logic rdy;
    logic z;
    logic [31:0] res;
    logic [31:0] h;
    logic [31:0] l;
    bad = 0;
    if (w8) begin
      b8.ALUOp = op; b8.src1 = a[7:0]; b8.src2 = b[7:0]; b8.shamt = sh[2:0]; b8.start = 1'b1;
    end else begin
      b32.ALUOp = op; b32.src1 = a; b32.src2 = b; b32.shamt = sh; b32.start = 1'b1;
    end
    for (int e = 1; e <= lat; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        b8.start  = 1'b0;
        b32.start = 1'b0;
      end
      rv  = w8 ? b8.result_valid : b32.result_valid;
      rdy = w8 ? b8.ready : b32.ready;
      if (e < lat) begin
        if (rv !== 1'b0 || rdy !== 1'b0) bad++;
      end
    end
    res = w8 ? {24'h0, b8.ALU_result} : b32.ALU_result;
    h   = w8 ? {24'h0, b8.hi} : b32.hi;
    l   = w8 ? {24'h0, b8.lo} : b32.lo;
    z   = w8 ? b8.Zero : b32.Zero;
    chk({nm, "_busy"},  64'(bad), 64'(0));
    chk({nm, "_valid"}, 64'(rv),  64'(1));
    chk({nm, "_ready"}, 64'(rdy), 64'(1));
    chk({nm, "_res"},   64'(res), 64'(exp_res));
    chk({nm, "_zero"},  64'(z),   64'(exp_res == 32'h0));
    chk({nm, "_hi"},    64'(h),   64'(exp_hi));
    chk({nm, "_lo"},    64'(l),   64'(exp_lo));
  endtask

  initial begin
    int bad;
    n_total = 0;
    n_pass  = 0;
    clk = 1'b0;
    rst = 1'b1;
    b32.start = 1'b0; b32.ALUOp = 4'h0; b32.src1 = 32'h0; b32.src2 = 32'h0; b32.shamt = 5'h0;
    b8.start  = 1'b0; b8.ALUOp  = 4'h0; b8.src1  = 8'h0;  b8.src2  = 8'h0;  b8.shamt  = 3'h0;

    vecs[0]  = mk(1'b0, ALU_ADD,   32'h7FFFFFFF, 32'h1,        5'd0,  1,  32'h80000000, 32'h0, 32'h0);
    vecs[1]  = mk(1'b0, ALU_SUB,   32'h5,        32'h5,        5'd0,  1,  32'h0,        32'h0, 32'h0);
    vecs[2]  = mk(1'b0, ALU_SLT,   32'hFFFFFFFF, 32'h1,        5'd0,  1,  32'h1,        32'h0, 32'h0);
    vecs[3]  = mk(1'b0, ALU_SLT,   32'h1,        32'hFFFFFFFF, 5'd0,  1,  32'h0,        32'h0, 32'h0);
    vecs[4]  = mk(1'b0, ALU_SRA,   32'h0,        32'h80000000, 5'd4,  1,  32'hF8000000, 32'h0, 32'h0);
    vecs[5]  = mk(1'b0, ALU_SRL,   32'h0,        32'h80000000, 5'd4,  1,  32'h08000000, 32'h0, 32'h0);
    vecs[6]  = mk(1'b0, ALU_SLL,   32'h0,        32'h3,        5'd31, 1,  32'h80000000, 32'h0, 32'h0);
    vecs[7]  = mk(1'b0, ALU_AND,   32'hF0F0,     32'hFF00,     5'd0,  1,  32'hF000,     32'h0, 32'h0);
    vecs[8]  = mk(1'b0, ALU_OR,    32'hF0F0,     32'h0F0F,     5'd0,  1,  32'hFFFF,     32'h0, 32'h0);
    vecs[9]  = mk(1'b0, ALU_XOR,   32'hFFFF,     32'h0F0F,     5'd0,  1,  32'hF0F0,     32'h0, 32'h0);
    vecs[10] = mk(1'b0, ALU_NOR,   32'h0,        32'h0,        5'd0,  1,  32'hFFFFFFFF, 32'h0, 32'h0);
    vecs[11] = mk(1'b0, ALU_ADD,   32'hFFFFFFFF, 32'h1,        5'd0,  1,  32'h0,        32'h0, 32'h0);
    vecs[12] = mk(1'b1, ALU_ADD,   32'h7F,       32'h1,        5'd0,  1,  32'h80,       32'h0, 32'h0);
    vecs[13] = mk(1'b1, ALU_SRA,   32'h0,        32'h80,       5'd3,  1,  32'hF0,       32'h0, 32'h0);
    vecs[14] = mk(1'b1, ALU_DIV,   32'hF9,       32'h02,       5'd0,  10, 32'hFD,       32'hFF, 32'hFD);
    vecs[15] = mk(1'b1, ALU_DIVU,  32'hC8,       32'h07,       5'd0,  10, 32'h1C,       32'h04, 32'h1C);
    vecs[16] = mk(1'b1, ALU_DIV,   32'h80,       32'hFF,       5'd0,  10, 32'h80,       32'h00, 32'h80);
    vecs[17] = mk(1'b1, ALU_MULTU, 32'hFF,       32'hFF,       5'd0,  10, 32'h01,       32'hFE, 32'h01);
    vecs[18] = mk(1'b1, ALU_MFHI,  32'h0,        32'h0,        5'd0,  1,  32'hFE,       32'hFE, 32'h01);
    vecs[19] = mk(1'b1, ALU_MULT,  32'h80,       32'h80,       5'd0,  10, 32'h00,       32'h40, 32'h00);
    vecs[20] = mk(1'b1, ALU_MFLO,  32'h0,        32'h0,        5'd0,  1,  32'h00,       32'h40, 32'h00);
    vecs[21] = mk(1'b0, ALU_MULTU, 32'h10000,    32'h10000,    5'd0,  34, 32'h0,        32'h1, 32'h0);
    vecs[22] = mk(1'b0, ALU_DIV,   32'hFFFFFFF9, 32'h2,        5'd0,  34, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD);
    vecs[23] = mk(1'b1, ALU_DIV,   32'hF9,       32'h00,       5'd0,  2,  32'hFF,       32'hF9, 32'hFF);
    vecs[24] = mk(1'b0, ALU_DIVU,  32'h1234,     32'h0,        5'd0,  2,  32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFF);

    // Reset values while rst is held.
    #12;
    chk("rst_ready",  64'(b32.ready),        64'(1));
    chk("rst_valid",  64'(b32.result_valid), 64'(0));
    chk("rst_result", 64'(b32.ALU_result),   64'(0));
    chk("rst_zero",   64'(b32.Zero),         64'(1));
    chk("rst_hi",     64'(b32.hi),           64'(0));
    chk("rst_lo",     64'(b32.lo),           64'(0));
    chk("rst_ready8", 64'(b8.ready),         64'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].sh, vecs[i].lat, vecs[i].res, vecs[i].hi, vecs[i].lo);
    end

    // mult -3 x 7 with a start pulse and operand change while busy.
    bad = 0;
    b32.ALUOp = ALU_MULT; b32.src1 = 32'hFFFFFFFD; b32.src2 = 32'h7; b32.start = 1'b1;
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) b32.start = 1'b0;
      if (e == 5) begin
        b32.start = 1'b1; b32.ALUOp = ALU_ADD; b32.src1 = 32'h1; b32.src2 = 32'h1;
      end
      if (e == 6) b32.start = 1'b0;
      if (e < 34) begin
        if (b32.ready !== 1'b0 || b32.result_valid !== 1'b0) bad++;
      end
    end
    chk("mult_busy",  64'(bad),              64'(0));
    chk("mult_valid", 64'(b32.result_valid), 64'(1));
    chk("mult_ready", 64'(b32.ready),        64'(1));
    chk("mult_hi",    64'(b32.hi),           64'(32'hFFFFFFFF));
    chk("mult_lo",    64'(b32.lo),           64'(32'hFFFFFFEB));
    chk("mult_res",   64'(b32.ALU_result),   64'(32'hFFFFFFEB));
    chk("mult_zero",  64'(b32.Zero),         64'(0));

    // mfhi accepted in the same cycle the mult result is valid.
    run_op("b2b_mfhi", 1'b0, ALU_MFHI, 32'h0, 32'h0, 5'd0, 1,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFEB);

    // Reset in the middle of a divide.
    b32.ALUOp = ALU_DIVU; b32.src1 = 32'd100; b32.src2 = 32'd3; b32.start = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) b32.start = 1'b0;
    end
    chk("div_busy_pre_rst", 64'(b32.ready), 64'(0));
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready",  64'(b32.ready),        64'(1));
    chk("mid_rst_valid",  64'(b32.result_valid), 64'(0));
    chk("mid_rst_hi",     64'(b32.hi),           64'(0));
    chk("mid_rst_lo",     64'(b32.lo),           64'(0));
    chk("mid_rst_result", 64'(b32.ALU_result),   64'(0));
    chk("mid_rst_zero",   64'(b32.Zero),         64'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op("post_rst_add", 1'b0, ALU_ADD, 32'd2, 32'd3, 5'd0, 1, 32'd5, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
